// File: rtl/vga_write_arbiter_pkg.sv
// Shared definitions for the VGA write-port arbiter: issue-type codes,
// requester indices and the queued write entry.
package vga_write_arbiter_pkg;

    localparam int unsigned DATA_WIDTH       = 32;
    localparam int unsigned ISSUE_TYPE_WIDTH = 2;

    localparam logic [ISSUE_TYPE_WIDTH-1:0] ISSUE_NONE = 2'd0;
    localparam logic [ISSUE_TYPE_WIDTH-1:0] KEYPAD     = 2'd1;
    localparam logic [ISSUE_TYPE_WIDTH-1:0] SWITCH     = 2'd2;
    localparam logic [ISSUE_TYPE_WIDTH-1:0] CPU_STORE  = 2'd3;

    localparam int unsigned VGA_ARB_REQ_CPU    = 0;
    localparam int unsigned VGA_ARB_REQ_KEYPAD = 1;
    localparam int unsigned VGA_ARB_REQ_SWITCH = 2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]       data;
        logic [ISSUE_TYPE_WIDTH-1:0] itype;
    } vga_wr_entry_t;

endpackage

// File: rtl/vga_write_fifo.sv
// Synchronous FIFO with push/pop, occupancy count and full/empty flags.
// Push while full and pop while empty are ignored.
module vga_write_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the VGA output-unit write port between
// requesters, buffered through a small FIFO and optionally drained only
// during blanking so the displayed frame does not tear.
module vga_write_arbiter
    import vga_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BLANK_ONLY = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]        req_data,
    input  logic [ISSUE_TYPE_WIDTH*NUM_REQ-1:0]  req_type,
    output logic [NUM_REQ-1:0]                   gnt,
    input  logic                                 display_en,
    output logic                                 vga_write_enable,
    output logic [DATA_WIDTH-1:0]                vga_store_data,
    output logic [ISSUE_TYPE_WIDTH-1:0]          issue_type,
    output logic                                 fifo_full,
    output logic                                 busy
);

    localparam int unsigned RR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned ENTRY_W = $bits(vga_wr_entry_t);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic [RR_W-1:0]             r_rr_ptr;
    logic                        r_disp_meta;
    logic                        r_disp_s;
    logic                        r_we;
    logic [DATA_WIDTH-1:0]       r_data;
    logic [ISSUE_TYPE_WIDTH-1:0] r_type;

    logic [NUM_REQ-1:0]          w_gnt;
    logic                        w_gnt_vld;
    logic [RR_W-1:0]             w_gnt_idx;
    vga_wr_entry_t               w_push_entry;
    vga_wr_entry_t               w_head;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [CNT_W-1:0]            w_count;

    // Round-robin scan starting at r_rr_ptr; picks the first asserted request.
    always_comb begin
        int unsigned idx;
        idx          = 0;
        w_gnt        = '0;
        w_gnt_vld    = 1'b0;
        w_gnt_idx    = '0;
        w_push_entry = '0;
        if (!rst && !w_full) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = (32'(r_rr_ptr) + k) % NUM_REQ;
                if (!w_gnt_vld && req[idx]) begin
                    w_gnt_vld          = 1'b1;
                    w_gnt[idx]         = 1'b1;
                    w_gnt_idx          = RR_W'(idx);
                    w_push_entry.data  = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
                    w_push_entry.itype = req_type[idx*ISSUE_TYPE_WIDTH +: ISSUE_TYPE_WIDTH];
                end
            end
        end
    end

    // Next search starts just after the last winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_vld) begin
            r_rr_ptr <= (w_gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + RR_W'(1);
        end
    end

    // Two-flop display_en synchronizer; resets to active video so nothing drains early.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_meta <= 1'b1;
            r_disp_s    <= 1'b1;
        end else begin
            r_disp_meta <= display_en;
            r_disp_s    <= r_disp_meta;
        end
    end

    assign w_pop = !w_empty && ((BLANK_ONLY == 0) || !r_disp_s);

    vga_write_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_gnt_vld),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Output registers: one-cycle strobe per popped entry, data/type hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_data <= '0;
            r_type <= ISSUE_NONE;
        end else begin
            r_we <= w_pop;
            if (w_pop) begin
                r_data <= w_head.data;
                r_type <= w_head.itype;
            end
        end
    end

    assign gnt              = w_gnt;
    assign vga_write_enable = r_we;
    assign vga_store_data   = r_data;
    assign issue_type       = r_type;
    assign fifo_full        = w_full;
    assign busy             = (w_count != '0) || r_we;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed self-checking bench for vga_write_arbiter (NUM_REQ=3, depth 4, blank-only drain).
module tb_vga_write_arbiter;
    import vga_write_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [95:0] req_data;
    logic [5:0]  req_type;
    logic [2:0]  gnt;
    logic        display_en;
    logic        we;
    logic [31:0] sd;
    logic [1:0]  it;
    logic        full;
    logic        busy;

    int checks_total    = 0;
    int checks_passed   = 0;
    int hold_violations = 0;
    logic [2:0] pending = '0;

    vga_write_arbiter #(.NUM_REQ(3), .FIFO_DEPTH(4), .BLANK_ONLY(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .req_data         (req_data),
        .req_type         (req_type),
        .gnt              (gnt),
        .display_en       (display_en),
        .vga_write_enable (we),
        .vga_store_data   (sd),
        .issue_type       (it),
        .fifo_full        (full),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Protocol monitor: gnt only to requesting ports, at most one-hot, zero in reset;
    // flags requesters that drop req before being granted.
    always @(negedge clk) begin
        checks_total++;
        if (rst) begin
            if (gnt !== 3'b000) $display("FAIL mon_gnt_in_reset: got %b exp 000", gnt);
            else checks_passed++;
            pending <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pending[i] && !req[i]) begin
                    hold_violations++;
                    $display("hold rule: requester %0d dropped req before grant", i);
                end
            end
            if (((gnt & ~req) !== 3'b000) || ($countones(gnt) > 1))
                $display("FAIL mon_gnt_legal: got gnt %b req %b exp onehot subset", gnt, req);
            else checks_passed++;
            pending <= req & ~gnt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = 3'b000;
        step();
        rst = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 3'b111; display_en = 1'b0;
        step(); step();
        checks_total++; if (we !== 1'b0) $display("FAIL rst_we: got %b exp 0", we); else checks_passed++;
        checks_total++; if (sd !== 32'h0) $display("FAIL rst_data: got %h exp 0", sd); else checks_passed++;
        checks_total++; if (it !== ISSUE_NONE) $display("FAIL rst_type: got %h exp %h", it, ISSUE_NONE); else checks_passed++;
        checks_total++; if (full !== 1'b0) $display("FAIL rst_full: got %b exp 0", full); else checks_passed++;
        checks_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else checks_passed++;
        checks_total++; if (dut.r_rr_ptr !== 2'd0) $display("FAIL rst_rr: got %0d exp 0", dut.r_rr_ptr); else checks_passed++;
        #1;
        checks_total++; if (gnt !== 3'b000) $display("FAIL rst_gnt: got %b exp 000", gnt); else checks_passed++;
        req = 3'b000; rst = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_single();
        req = 3'b010; req_data[63:32] = 32'h8000_0008; req_type[3:2] = KEYPAD;
        #1;
        checks_total++; if (gnt !== 3'b010) $display("FAIL single_gnt: got %b exp 010", gnt); else checks_passed++;
        step();
        req = 3'b000;
        checks_total++; if (we !== 1'b0) $display("FAIL single_we_c1: got %b exp 0", we); else checks_passed++;
        checks_total++; if (busy !== 1'b1) $display("FAIL single_busy_c1: got %b exp 1", busy); else checks_passed++;
        step();
        checks_total++; if (we !== 1'b1) $display("FAIL single_we_c2: got %b exp 1", we); else checks_passed++;
        checks_total++; if (sd !== 32'h8000_0008) $display("FAIL single_data: got %h exp 80000008", sd); else checks_passed++;
        checks_total++; if (it !== KEYPAD) $display("FAIL single_type: got %h exp %h", it, KEYPAD); else checks_passed++;
        step();
        checks_total++; if (we !== 1'b0) $display("FAIL single_we_c3: got %b exp 0", we); else checks_passed++;
        checks_total++; if (busy !== 1'b0) $display("FAIL single_busy_c3: got %b exp 0", busy); else checks_passed++;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_d [3];
        logic [1:0]  exp_t [3];
        logic [2:0]  exp_g;
        exp_d[0] = 32'hAAAA_0001; exp_d[1] = 32'hBBBB_0002; exp_d[2] = 32'hCCCC_0003;
        exp_t[0] = CPU_STORE;     exp_t[1] = KEYPAD;        exp_t[2] = SWITCH;
        display_en = 1'b0;
        apply_reset();
        req_data = {exp_d[2], exp_d[1], exp_d[0]};
        req_type = {exp_t[2], exp_t[1], exp_t[0]};
        req = 3'b111;
        for (int c = 0; c < 8; c++) begin
            if (c >= 2) begin
                checks_total++;
                if (we !== 1'b1 || sd !== exp_d[(c-2)%3] || it !== exp_t[(c-2)%3])
                    $display("FAIL rr_out_c%0d: got we=%b %h/%h exp we=1 %h/%h", c, we, sd, it, exp_d[(c-2)%3], exp_t[(c-2)%3]);
                else checks_passed++;
            end
            if (c >= 4 && c <= 6) req[c-4] = 1'b0;
            #1;
            exp_g = (c < 6) ? 3'(1 << (c % 3)) : 3'b000;
            checks_total++;
            if (gnt !== exp_g) $display("FAIL rr_gnt_c%0d: got %b exp %b", c, gnt, exp_g);
            else checks_passed++;
            step();
        end
        checks_total++; if (we !== 1'b0 || busy !== 1'b0) $display("FAIL rr_idle: got we=%b busy=%b exp 0/0", we, busy); else checks_passed++;
    endtask

    task automatic test_blank_gating();
        int n = 0;
        int wc = 0;
        int first_write = -1;
        display_en = 1'b1;
        apply_reset();
        req_type[1:0] = CPU_STORE;
        for (int c = 0; c < 20; c++) begin
            if (c == 6) display_en = 1'b0;
            req[0] = (n < 6);
            req_data[31:0] = 32'hD000_0000 + 32'(n);
            if (we === 1'b1) begin
                if (first_write < 0) first_write = c;
                checks_total++;
                if (sd !== 32'hD000_0000 + 32'(wc) || it !== CPU_STORE)
                    $display("FAIL blank_order_%0d: got %h/%h exp %h/%h", wc, sd, it, 32'hD000_0000 + 32'(wc), CPU_STORE);
                else checks_passed++;
                wc++;
            end
            if (c >= 4 && c <= 8) begin
                checks_total++; if (we !== 1'b0) $display("FAIL blank_nostrobe_c%0d: got %b exp 0", c, we); else checks_passed++;
                checks_total++; if (full !== 1'b1) $display("FAIL blank_full_c%0d: got %b exp 1", c, full); else checks_passed++;
            end
            #1;
            if (c < 4) begin
                checks_total++; if (gnt !== 3'b001) $display("FAIL blank_gnt_c%0d: got %b exp 001", c, gnt); else checks_passed++;
            end else if (c <= 8) begin
                checks_total++; if (gnt !== 3'b000) $display("FAIL blank_stall_c%0d: got %b exp 000", c, gnt); else checks_passed++;
            end
            if (gnt[0] === 1'b1) n++;
            step();
        end
        checks_total++; if (first_write !== 9) $display("FAIL blank_first_write: got cycle %0d exp 9", first_write); else checks_passed++;
        checks_total++; if (wc !== 6) $display("FAIL blank_write_count: got %0d exp 6", wc); else checks_passed++;
        checks_total++; if (n !== 6) $display("FAIL blank_grant_count: got %0d exp 6", n); else checks_passed++;
    endtask

    task automatic test_push_pop_wrap();
        int n = 0;
        int wc = 0;
        display_en = 1'b1;
        apply_reset();
        req_type[5:4] = SWITCH;
        for (int c = 0; c < 20; c++) begin
            if (c == 2) display_en = 1'b0;
            req[2] = (n < 2) || (c >= 4 && n < 8);
            req_data[95:64] = 32'hC0DE_0000 + 32'(n);
            if (we === 1'b1) begin
                checks_total++;
                if (sd !== 32'hC0DE_0000 + 32'(wc) || it !== SWITCH)
                    $display("FAIL pp_data_%0d: got %h/%h exp %h/%h", wc, sd, it, 32'hC0DE_0000 + 32'(wc), SWITCH);
                else checks_passed++;
                wc++;
            end
            if (c >= 4 && c <= 10) begin
                checks_total++;
                if (dut.u_fifo.r_count !== 3'd2) $display("FAIL pp_count_c%0d: got %0d exp 2", c, dut.u_fifo.r_count);
                else checks_passed++;
            end
            if (c == 10) begin
                checks_total++; if (dut.u_fifo.r_wr_ptr !== 2'd0) $display("FAIL pp_wr_ptr: got %0d exp 0", dut.u_fifo.r_wr_ptr); else checks_passed++;
                checks_total++; if (dut.u_fifo.r_rd_ptr !== 2'd2) $display("FAIL pp_rd_ptr: got %0d exp 2", dut.u_fifo.r_rd_ptr); else checks_passed++;
            end
            #1;
            if (gnt[2] === 1'b1) n++;
            step();
        end
        checks_total++; if (wc !== 8) $display("FAIL pp_write_count: got %0d exp 8", wc); else checks_passed++;
    endtask

    task automatic test_reset_mid_op();
        int wc = 0;
        display_en = 1'b1;
        apply_reset();
        req_type[1:0] = CPU_STORE;
        for (int c = 0; c < 3; c++) begin
            req[0] = 1'b1;
            req_data[31:0] = 32'hBAD0_0000 + 32'(c);
            step();
        end
        rst = 1'b1;
        req_data[31:0] = 32'h600D_600D;
        #1;
        checks_total++; if (gnt !== 3'b000) $display("FAIL rmo_gnt_in_rst: got %b exp 000", gnt); else checks_passed++;
        step();
        rst = 1'b0;
        display_en = 1'b0;
        checks_total++; if (busy !== 1'b0) $display("FAIL rmo_busy: got %b exp 0", busy); else checks_passed++;
        checks_total++; if (we !== 1'b0) $display("FAIL rmo_we: got %b exp 0", we); else checks_passed++;
        checks_total++; if (dut.r_rr_ptr !== 2'd0) $display("FAIL rmo_rr: got %0d exp 0", dut.r_rr_ptr); else checks_passed++;
        #1;
        checks_total++; if (gnt !== 3'b001) $display("FAIL rmo_regrant: got %b exp 001", gnt); else checks_passed++;
        step();
        req = 3'b000;
        for (int c = 0; c < 12; c++) begin
            if (we === 1'b1) begin
                checks_total++;
                if (sd !== 32'h600D_600D) $display("FAIL rmo_data: got %h exp 600d600d", sd);
                else checks_passed++;
                wc++;
            end
            step();
        end
        checks_total++; if (wc !== 1) $display("FAIL rmo_write_count: got %0d exp 1", wc); else checks_passed++;
    endtask

    task automatic test_hold_rule();
        int n = 0;
        int wc = 0;
        logic h_granted = 1'b0;
        display_en = 1'b1;
        apply_reset();
        hold_violations = 0;
        req_type = {SWITCH, KEYPAD, CPU_STORE};
        req_data[63:32] = 32'h4444_4444;
        for (int c = 0; c < 25; c++) begin
            if (c == 6) display_en = 1'b0;
            req[0] = (n < 4);
            req_data[31:0] = 32'h1000_0000 + 32'(n);
            req[1] = (c == 4) || (c >= 12 && !h_granted);
            if (we === 1'b1) begin
                checks_total++;
                if (sd !== ((wc < 4) ? 32'h1000_0000 + 32'(wc) : 32'h4444_4444))
                    $display("FAIL hold_data_%0d: got %h exp %h", wc, sd, (wc < 4) ? 32'h1000_0000 + 32'(wc) : 32'h4444_4444);
                else checks_passed++;
                wc++;
            end
            #1;
            if (c == 4) begin
                checks_total++;
                if (gnt !== 3'b000 || full !== 1'b1) $display("FAIL hold_full_stall: got gnt=%b full=%b exp 000/1", gnt, full);
                else checks_passed++;
            end
            if (c < 12) begin
                checks_total++; if (gnt[1] !== 1'b0) $display("FAIL hold_no_grant_c%0d: got %b exp 0", c, gnt[1]); else checks_passed++;
            end
            if (c == 12) begin
                checks_total++; if (gnt !== 3'b010) $display("FAIL hold_regrant: got %b exp 010", gnt); else checks_passed++;
            end
            if (gnt[0] === 1'b1) n++;
            if (gnt[1] === 1'b1) h_granted = 1'b1;
            step();
        end
        checks_total++; if (wc !== 5) $display("FAIL hold_write_count: got %0d exp 5", wc); else checks_passed++;
        checks_total++; if (hold_violations !== 1) $display("FAIL hold_flagged: got %0d exp 1", hold_violations); else checks_passed++;
    endtask

    initial begin
        rst        = 1'b1;
        req        = 3'b000;
        req_data   = '0;
        req_type   = '0;
        display_en = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_blank_gating();
        test_push_pop_wrap();
        test_reset_mid_op();
        test_hold_rule();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Shares the single VGA output-unit write port (vga_write_enable / vga_store_data / issue_type) between NUM_REQ requesters: CPU MMIO store path, keypad issue, switch-display issue.
- Round-robin grant into a small FIFO, which is then drained one write per cycle to the output unit.
- When BLANK_ONLY=1, drain happens only while display_en is low, so the displayed frame does not tear.
- Sits between the pipeline/IO front-end and the output unit; runs entirely on clk.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = CPU, 1 = keypad, 2 = switch.
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
- BLANK_ONLY, 1, 1 = drain only while synchronized display_en = 0; 0 = drain whenever the FIFO is non-empty.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  NUM_REQ  per-requester request; held until the matching gnt bit pulses.
- req_data  in  32*NUM_REQ  flattened store data; slice i belongs to requester i.
- req_type  in  `ISSUE_TYPE_WIDTH*NUM_REQ  flattened issue type per requester.
- gnt  out  NUM_REQ  one-hot, combinational; high in the cycle the request is accepted.
- display_en  in  1  active-video flag from vga_signal (clk_vga domain).
- vga_write_enable  out  1  one-cycle write strobe to the output unit; registered.
- vga_store_data  out  32  write data; registered.
- issue_type  out  `ISSUE_TYPE_WIDTH  write issue type; registered.
- fifo_full  out  1  count == FIFO_DEPTH.
- busy  out  1  FIFO non-empty or vga_write_enable high.

Behaviour:
- Reset:
  - Outputs: vga_write_enable=0, vga_store_data=0, issue_type=`ISSUE_NONE, fifo_full=0, busy=0.
  - Internal: FIFO count/pointers = 0, rr_ptr = 0, sync flops = 1 (treated as active video).
  - gnt=0 while rst is high.
  - Reset mid-operation discards all queued entries; a requester held on req is re-arbitrated after reset.
- Arbitration (combinational):
  - If fifo_full=0, grant the first asserted req scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - At most one gnt bit per cycle.
  - No grant while full; push-while-full is impossible, so there is no same-cycle push/pop bypass.
- rr_ptr update: on a grant to index i, rr_ptr <= (i+1) mod NUM_REQ; otherwise unchanged.
- Push: on grant, the {data, type} of the granted slice is written at wr_ptr at the clock edge. wr_ptr wraps modulo FIFO_DEPTH.
- display_en sync: 2-flop synchronizer to disp_s; no reset-release glitch (flops reset to 1).
- Drain condition: count > 0 and (BLANK_ONLY == 0 or disp_s == 0).
  - On drain: head moves into the output registers, vga_write_enable <= 1 for exactly one cycle, rd_ptr advances.
  - Otherwise vga_write_enable <= 0; data and type hold their last values.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Count width: clog2(FIFO_DEPTH)+1; count never exceeds FIFO_DEPTH or underflows.
- Latency (empty FIFO, drain allowed): req/gnt in cycle 0; entry stored at end of cycle 0; popped in cycle 1; vga_write_enable high in cycle 2. Throughput is 1 write per cycle.
- BLANK_ONLY stall: entries stay queued while disp_s = 1. Once the FIFO fills, gnt stays 0 and requesters wait (no drops).
- Order: output order equals grant order.

Decomposition:
- Package (definitions.v):
  - `ISSUE_TYPE_WIDTH and the issue-type codes (`ISSUE_NONE, `KEYPAD, `SWITCH, `CPU_STORE), extended from the existing ones.
  - `VGA_ARB_REQ_CPU / _KEYPAD / _SWITCH index constants.
- Sub-module: vga_write_fifo (synchronous FIFO: push/pop/count/full/empty, parameterized width and depth).
- Arbiter, synchronizer and output registers stay in the top module.

Test Plan:
- Single request: BLANK_ONLY=0; req=3'b010, data 32'h8000_0008, type `KEYPAD in cycle 0.
  -> gnt=3'b010 in cycle 0; vga_write_enable=1 in cycle 2 only, with vga_store_data=32'h8000_0008 and issue_type=`KEYPAD.
- Round-robin: all three req held continuously with distinct data A/B/C; FIFO never full.
  -> grant order 0,1,2,0,1,2; outputs A,B,C,A,B,C on consecutive cycles.
- Blank gating: BLANK_ONLY=1, display_en=1; 6 requests from requester 0.
  -> 4 grants, fifo_full=1, gnt=0 thereafter, no write strobe. Then display_en=0.
  -> strobes start 3 cycles later (2 sync + 1 register) and the remaining 2 requests are then granted. Six writes total, in order.
- Simultaneous push/pop at count=2.
  -> count stays 2, pointers wrap correctly across the FIFO_DEPTH boundary, no data corruption.
- Reset mid-operation: rst=1 for 1 cycle with 3 entries queued.
  -> next cycle: busy=0, vga_write_enable=0, rr_ptr=0; none of the old data is ever emitted.
- Hold rule: requester 1 drops req before gnt (illegal).
  -> a bench assertion flags it; the arbiter grants it only when sampled high, and never grants an idle requester.
